// File: rtl/jtdsp16_loader_pkg.sv
// Shared jtdsp16 definitions: loader state encoding and default ROM geometry,
// also used to size the DSP16 ROM address.
package jtdsp16_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam int ROM_BYTES_DEF = 8192;
    localparam int AW_DEF        = 13;

endpackage

// File: rtl/jtdsp16_loader_if.sv
// Firmware download byte stream: the download logic is the master, the loader
// the slave.
interface jtdsp16_loader_if;

    logic [7:0] dl_data;
    logic       dl_valid;
    logic       dl_ready;

    modport master (output dl_data, output dl_valid, input dl_ready);
    modport slave  (input dl_data, input dl_valid, output dl_ready);

endinterface

// File: rtl/jtdsp16_loader.sv
// DSP16 boot sequencer: writes the firmware stream into the core ROM, then
// releases the core reset. Optional trailer checksum: JTDSP16_LOADER_CHECKSUM_EN.
module jtdsp16_loader
    import jtdsp16_loader_pkg::*;
#(
    parameter int ROM_BYTES = ROM_BYTES_DEF,
    parameter int AW        = AW_DEF,
    parameter int HOLD_CEN  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               start,
    jtdsp16_loader_if.slave    dl,
    output logic [AW-1:0]      prog_addr,
    output logic [7:0]         prog_data,
    output logic               prog_we,
    output logic               dsp_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int            HW        = $clog2(HOLD_CEN + 1);
    localparam logic [AW-1:0] LAST      = AW'(ROM_BYTES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CEN - 1);

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic [HW-1:0] hold_cnt;
    logic          xfer, data_xfer, last, restart, hold_end;

    assign dl.dl_ready = (state == LOAD);
    assign xfer        = dl.dl_valid && dl.dl_ready;
    assign last        = (cnt == LAST);
    assign restart     = start && (state == IDLE || state == RUN);
    assign hold_end    = cen && (hold_cnt == HOLD_LAST);

    assign dsp_rst = (state != RUN);
    assign busy    = (state == LOAD) || (state == HOLD);
    assign done    = (state == RUN);

`ifdef JTDSP16_LOADER_CHECKSUM_EN
    logic [7:0] sum, sum_nx;
    logic       trailer, sum_ok;

    // Once all data bytes are in, the next accepted byte is the trailer.
    assign sum_nx    = sum + dl.dl_data;
    assign sum_ok    = (sum_nx == 8'd0);
    assign data_xfer = xfer && !trailer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            trailer <= 1'b0;
            err     <= 1'b0;
        end else if (restart) begin
            sum     <= '0;
            trailer <= 1'b0;
            err     <= 1'b0;
        end else if (xfer) begin
            if (trailer) begin
                trailer <= 1'b0;
                err     <= !sum_ok;
            end else begin
                sum <= sum_nx;
                if (last) trailer <= 1'b1;
            end
        end
    end
`else
    assign data_xfer = xfer;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
`ifdef JTDSP16_LOADER_CHECKSUM_EN
                if (xfer && trailer) state_nx = sum_ok ? HOLD : IDLE;
`else
                if (xfer && last) state_nx = HOLD;
`endif
            end
            HOLD: if (hold_end) state_nx = RUN;
            RUN:  if (start) state_nx = LOAD;
        endcase
    end

    // Write stage: one registered ROM write per accepted data byte.
    // The counter wraps after the last byte, but LOAD is left at that point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            hold_cnt  <= '0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
        end else begin
            prog_we <= data_xfer;
            if (restart) begin
                cnt      <= '0;
                hold_cnt <= '0;
            end else if (data_xfer) begin
                prog_addr <= cnt;
                prog_data <= dl.dl_data;
                cnt       <= cnt + AW'(1);
            end
            if (state == HOLD && cen) hold_cnt <= hold_cnt + HW'(1);
        end
    end

endmodule
